pdm_decimator: RTL
==================

Name: pdm_decimator

Overview:
- PDM-to-PCM decoder: the receive-side counterpart of the PDM modulator feeding the speakers.
- Samples a 1-bit PDM microphone stream on each clock-enable tick and runs it through a 2nd-order CIC (integrate/comb) decimator.
- Emits signed 16-bit PCM samples on a valid/ready interface, for the FFT front end or the speaker path.
- Runs on the 98.304 MHz audio clock: tick every 32 cycles, DECIMATION=64, giving 48 kHz output.

Parameters:
- DECIMATION, 64: PDM ticks per output sample (R). Must be a power of two, 4..128.
- ACC_W, 2*$clog2(DECIMATION)+2: width of the integrator and comb registers. Two's-complement, wrap-around arithmetic.

Ports:
- clk_in  input  1  system/audio clock
- rst_in  input  1  reset; synchronous, active-high
- pdm_in  input  1  PDM bit, sampled only when tick_in=1
- tick_in  input  1  one-cycle PDM sample strobe (rising mic clock edge)
- sample_out  output  16  signed PCM sample
- sample_valid_out  output  1  sample_out holds an unconsumed sample
- sample_ready_in  input  1  consumer accepts sample this cycle
- overrun_out  output  1  sticky: a sample was overwritten before it was consumed

Behaviour:
- Reset (rst_in=1 at a clk edge) clears all state, including mid-window: integrators, comb delays, tick counter, prime counter, sample_out=0, sample_valid_out=0, overrun_out=0.
- Input mapping: x = +1 when pdm_in=1, x = -1 when pdm_in=0.
- On each tick_in=1:
  - i1 <= i1 + x
  - i2 <= i2 + i1 + x (uses the updated i1)
  - tick_cnt increments, modulo DECIMATION.
- Cycles with tick_in=0 change nothing, whatever pdm_in does.
- Decimation point: the tick with tick_cnt == DECIMATION-1. The following cycle is the comb stage, using the i2 value updated by that tick:
  - c1 = i2 - i2_d
  - c2 = c1 - c1_d
  - then i2_d <= i2 and c1_d <= c1.
- Scaling:
  - y = c2 <<< (15 - 2*log2(DECIMATION)).
  - Saturate to [-32768, 32767]; only +R^2 actually saturates, mapping to 32767.
  - -R^2 maps to -32768. A zero-mean stream maps to 0.
- Priming: the first 2 comb results after reset are discarded. They update the comb delays but not the output.
- Latency: sample_valid_out rises at the 2nd clk edge after the edge that sampled the decimation tick.
- Output register:
  - sample_out/sample_valid_out are loaded with y and 1 on a new (non-primed) result.
  - Once valid, they are held stable until a cycle with sample_valid_out && sample_ready_in (handshake).
  - After a handshake with no new result that cycle: sample_valid_out <= 0; sample_out keeps its last value.
- New result while sample_valid_out=1 and sample_ready_in=0: overwrite with the new sample, keep valid=1, set overrun_out=1. overrun_out clears only on reset.
- New result in the same cycle as a handshake: the old sample counts as consumed; load the new one, valid stays 1, no overrun.
- sample_ready_in is ignored while sample_valid_out=0. The decimator never stalls; PDM input is never back-pressured.
- Ticks on back-to-back cycles must be handled. The comb stage must not miss or duplicate a result even if the next window's first tick coincides with the comb cycle. This only matters for DECIMATION≥4 with continuous ticks.

Test Plan:
- All-ones: DECIMATION=64, tick every 32 cycles, pdm_in=1, ready=1. Expect the first output after 3 windows (192 ticks); every following sample = 32767, one per 64 ticks; overrun_out=0.
- All-zeros: same setup with pdm_in=0. Expect every sample = -32768.
- Balanced pattern: 32 ones then 32 zeros, repeating, aligned to windows. Expect every sample after priming = 0. Then switch to all-ones and expect samples to reach 32767 within 2 windows.
- Back-pressure: ready=0 across 2 decimation points. Expect valid=1, sample_out updates to the newer value, overrun_out=1 and sticky. Then assert ready for 1 cycle: valid drops the next cycle and overrun_out stays 1.
- Handshake collision: ready=1 held so the handshake lands on the load cycle. Expect valid to stay 1, the new value loaded, overrun_out=0.
- Reset mid-window: assert rst_in after 20 ticks, with the output valid and overrun set. Next cycle all outputs are 0. Then verify no output until 3 full windows of fresh ticks; pdm_in toggling with tick_in=0 produces no change.

Source files
------------

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decoder: second-order CIC decimator from a 1-bit PDM stream to
// signed 16-bit PCM, delivered on a valid/ready interface that never stalls.
module pdm_decimator #(
  parameter int unsigned DECIMATION = 64,
  parameter int unsigned ACC_W      = 2 * $clog2(DECIMATION) + 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pdm_in,
  input  logic        tick_in,
  output logic [15:0] sample_out,
  output logic        sample_valid_out,
  input  logic        sample_ready_in,
  output logic        overrun_out
);

  localparam int unsigned CntW  = $clog2(DECIMATION);
  localparam int unsigned Shift = 15 - 2 * CntW;
  localparam logic [CntW-1:0] CntLast = CntW'(DECIMATION - 1);

  logic        [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic        [ACC_W-1:0] i2_dly_q, i2_dly_d, c1_dly_q, c1_dly_d;
  logic        [CntW-1:0]  cnt_q, cnt_d;
  logic        [1:0]       prime_q, prime_d;
  logic                    comb_pend_q, comb_pend_d;
  logic                    new_q, new_d;
  logic        [15:0]      y_q, y_d;
  logic        [15:0]      sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic        [ACC_W-1:0] x;
  logic        [ACC_W-1:0] c1;
  logic signed [ACC_W-1:0] c2;
  logic signed [31:0]      c2_ext, y_wide;
  logic        [15:0]      y_sat;

  assign x = pdm_in ? ACC_W'(1) : '1;

  // Integrators and window counter advance only on PDM ticks.
  always_comb begin
    i1_d        = i1_q;
    i2_d        = i2_q;
    cnt_d       = cnt_q;
    comb_pend_d = 1'b0;
    if (tick_in) begin
      i1_d        = i1_q + x;
      i2_d        = i2_q + i1_d;
      cnt_d       = cnt_q + 1'b1;
      comb_pend_d = (cnt_q == CntLast);
    end
  end

  // Comb stage runs the cycle after the decimation tick; reads i2_q before a
  // coincident tick of the next window can modify it.
  always_comb begin
    c1       = i2_q - i2_dly_q;
    c2       = c1 - c1_dly_q;
    c2_ext   = 32'(c2);
    y_wide   = c2_ext <<< Shift;
    if (y_wide > 32'sd32767) begin
      y_sat = 16'h7fff;
    end else if (y_wide < -32'sd32768) begin
      y_sat = 16'h8000;
    end else begin
      y_sat = y_wide[15:0];
    end
    i2_dly_d = i2_dly_q;
    c1_dly_d = c1_dly_q;
    prime_d  = prime_q;
    y_d      = y_q;
    new_d    = 1'b0;
    if (comb_pend_q) begin
      i2_dly_d = i2_q;
      c1_dly_d = c1;
      y_d      = y_sat;
      // The first two results only fill the comb delays.
      if (prime_q == 2'd2) begin
        new_d = 1'b1;
      end else begin
        prime_d = prime_q + 2'd1;
      end
    end
  end

  // Output register: a new result always wins; a pending unconsumed one is overrun.
  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (new_q) begin
      sample_d = y_q;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready_in) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready_in) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i2_dly_q    <= '0;
      c1_dly_q    <= '0;
      cnt_q       <= '0;
      prime_q     <= '0;
      comb_pend_q <= 1'b0;
      new_q       <= 1'b0;
      y_q         <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i2_dly_q    <= i2_dly_d;
      c1_dly_q    <= c1_dly_d;
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      comb_pend_q <= comb_pend_d;
      new_q       <= new_d;
      y_q         <= y_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = ovr_q;

endmodule
